store_input_align: RTL and testbench

Store-path aligner for the split even/odd L1 data cache banks, on the write side of the cache. It accepts one store of 1/2/4/8 bytes per handshake and rotates the data into 16-byte line position with a byte-enable mask. When a store crosses a line boundary it splits into two line writes, one per bank. It holds each bank request until that bank accepts, then signals completion.

---
 rtl/store_input_align.sv | 214 +++++++++++++++++++++
 tb/tb_store_input_align.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_input_align.sv
// Store-path aligner: places a 1/2/4/8-byte store into 16-byte line position for the
// even/odd cache banks, splitting line-crossing stores into two bank writes.
`timescale 1ns/1ps

module store_input_align (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [63:0]  req_data,
    input  logic [1:0]   req_size,
    input  logic [31:0]  req_vAddress,
    input  logic [14:0]  req_pAddress0,
    input  logic [14:0]  req_pAddress1,
    output logic         E_valid,
    input  logic         E_ready,
    output logic [127:0] E_data,
    output logic [15:0]  E_mask,
    output logic [14:0]  E_pAddress,
    output logic [31:0]  E_vAddress,
    output logic         O_valid,
    input  logic         O_ready,
    output logic [127:0] O_data,
    output logic [15:0]  O_mask,
    output logic [14:0]  O_pAddress,
    output logic [31:0]  O_vAddress,
    output logic         wr_done,
    output logic         split
);

    localparam int LINE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   pend_e_q, pend_e_d;
    logic   pend_o_q, pend_o_d;
    logic   load;

    logic [127:0] e_data_q, o_data_q;
    logic [15:0]  e_mask_q, o_mask_q;
    logic [14:0]  e_paddr_q, o_paddr_q;
    logic [31:0]  e_vaddr_q, o_vaddr_q;
    logic         split_q;

    // ------------------------------------------------------------------
    // Placement of the incoming store into a 32-byte (two-line) window
    // ------------------------------------------------------------------
    logic [3:0]   off;
    logic         bank_sel;
    logic [7:0]   byte_en;
    logic [4:0]   n_bytes;
    logic [63:0]  data_trim;
    logic [255:0] placed;
    logic [31:0]  mask_wide;
    logic         is_split;

    logic [127:0] line0_data, line1_data;
    logic [15:0]  line0_mask, line1_mask;
    logic [14:0]  line0_paddr, line1_paddr;
    logic [31:0]  line0_vaddr, line1_vaddr;

    logic [127:0] e_data_new, o_data_new;
    logic [15:0]  e_mask_new, o_mask_new;
    logic [14:0]  e_paddr_new, o_paddr_new;
    logic [31:0]  e_vaddr_new, o_vaddr_new;

    // Low nibble of the next-line address is forced to zero, so it is never read.
    logic unused_paddr1_lsbs;
    assign unused_paddr1_lsbs = ^req_pAddress1[3:0];

    assign off      = req_pAddress0[3:0];
    assign bank_sel = req_pAddress0[4];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        byte_en = 8'h01;
        n_bytes = 5'd1;
        case (req_size)
            2'b00: begin byte_en = 8'h01; n_bytes = 5'd1; end
            2'b01: begin byte_en = 8'h03; n_bytes = 5'd2; end
            2'b10: begin byte_en = 8'h0F; n_bytes = 5'd4; end
            default: begin byte_en = 8'hFF; n_bytes = 5'd8; end
        endcase
    end

    always_comb begin
        data_trim = '0;
        for (int k = 0; k < 8; k++) begin
            data_trim[k*8 +: 8] = byte_en[k] ? req_data[k*8 +: 8] : 8'h00;
        end
    end

    assign placed    = {192'b0, data_trim} << {off, 3'b000};
    assign mask_wide = {24'b0, byte_en} << off;
    assign is_split  = ({1'b0, off} + n_bytes) > 5'(LINE_BYTES);

    assign line0_data  = placed[127:0];
    assign line1_data  = placed[255:128];
    assign line0_mask  = mask_wide[15:0];
    // Bytes past the first line land in the upper half; zero whenever the store fits.
    assign line1_mask  = mask_wide[31:16];
    assign line0_paddr = {req_pAddress0[14:4], 4'b0000};
    assign line1_paddr = {req_pAddress1[14:4], 4'b0000};
    assign line0_vaddr = req_vAddress;
    assign line1_vaddr = {req_vAddress[31:4] + 28'd1, 4'b0000};

    // Line0 goes to the bank picked by address bit 4, line1 to the other one.
    always_comb begin
        if (bank_sel == 1'b0) begin
            e_data_new  = line0_data;   o_data_new  = line1_data;
            e_mask_new  = line0_mask;   o_mask_new  = line1_mask;
            e_paddr_new = line0_paddr;  o_paddr_new = line1_paddr;
            e_vaddr_new = line0_vaddr;  o_vaddr_new = line1_vaddr;
        end else begin
            e_data_new  = line1_data;   o_data_new  = line0_data;
            e_mask_new  = line1_mask;   o_mask_new  = line0_mask;
            e_paddr_new = line1_paddr;  o_paddr_new = line0_paddr;
            e_vaddr_new = line1_vaddr;  o_vaddr_new = line0_vaddr;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pend_e_d = pend_e_q;
        pend_o_d = pend_o_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load     = 1'b1;
                    pend_e_d = |e_mask_new;
                    pend_o_d = |o_mask_new;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (E_valid && E_ready) pend_e_d = 1'b0;
                if (O_valid && O_ready) pend_o_d = 1'b0;
                if (!pend_e_d && !pend_o_d) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                pend_e_d = 1'b0;
                pend_o_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pend_e_q <= 1'b0;
            pend_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_e_q <= pend_e_d;
            pend_o_q <= pend_o_d;
        end
    end

    // NOTE: datapath registers are reset too, so outputs read as zero after reset, not X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_data_q  <= '0;
            o_data_q  <= '0;
            e_mask_q  <= '0;
            o_mask_q  <= '0;
            e_paddr_q <= '0;
            o_paddr_q <= '0;
            e_vaddr_q <= '0;
            o_vaddr_q <= '0;
            split_q   <= 1'b0;
        end else if (load) begin
            e_data_q  <= e_data_new;
            o_data_q  <= o_data_new;
            e_mask_q  <= e_mask_new;
            o_mask_q  <= o_mask_new;
            e_paddr_q <= e_paddr_new;
            o_paddr_q <= o_paddr_new;
            e_vaddr_q <= e_vaddr_new;
            o_vaddr_q <= o_vaddr_new;
            split_q   <= is_split;
        end
    end

    // Handshake outputs depend on registered state only; bank readies never reach req_ready.
    assign req_ready  = (state_q == IDLE);
    assign E_valid    = (state_q == BUSY) && pend_e_q;
    assign O_valid    = (state_q == BUSY) && pend_o_q;
    assign wr_done    = (state_q == DONE);
    assign split      = split_q;

    assign E_data     = e_data_q;
    assign E_mask     = e_mask_q;
    assign E_pAddress = e_paddr_q;
    assign E_vAddress = e_vaddr_q;
    assign O_data     = o_data_q;
    assign O_mask     = o_mask_q;
    assign O_pAddress = o_paddr_q;
    assign O_vAddress = o_vaddr_q;

endmodule

// File: tb/tb_store_input_align.sv
// Directed bench for store_input_align: hand-computed placements, masks and handshake timing.
`timescale 1ns/1ps

module tb_store_input_align;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_data;
    logic [1:0]   req_size;
    logic [31:0]  req_vAddress;
    logic [14:0]  req_pAddress0;
    logic [14:0]  req_pAddress1;
    logic         E_valid, O_valid;
    logic         E_ready, O_ready;
    logic [127:0] E_data, O_data;
    logic [15:0]  E_mask, O_mask;
    logic [14:0]  E_pAddress, O_pAddress;
    logic [31:0]  E_vAddress, O_vAddress;
    logic         wr_done;
    logic         split;

    int total = 0;
    int bad   = 0;

    store_input_align dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_size      (req_size),
        .req_vAddress  (req_vAddress),
        .req_pAddress0 (req_pAddress0),
        .req_pAddress1 (req_pAddress1),
        .E_valid       (E_valid),
        .E_ready       (E_ready),
        .E_data        (E_data),
        .E_mask        (E_mask),
        .E_pAddress    (E_pAddress),
        .E_vAddress    (E_vAddress),
        .O_valid       (O_valid),
        .O_ready       (O_ready),
        .O_data        (O_data),
        .O_mask        (O_mask),
        .O_pAddress    (O_pAddress),
        .O_vAddress    (O_vAddress),
        .wr_done       (wr_done),
        .split         (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [14:0] pa0, input logic [14:0] pa1,
                             input logic [1:0] size, input logic [63:0] data,
                             input logic [31:0] va);
        req_valid     = 1'b1;
        req_pAddress0 = pa0;
        req_pAddress1 = pa1;
        req_size      = size;
        req_data      = data;
        req_vAddress  = va;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_data = '0; req_size = '0;
        req_vAddress = '0; req_pAddress0 = '0; req_pAddress1 = '0;
        E_ready = 1'b0; O_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_req_ready", 128'(req_ready), 128'(1'b1));
        check("rst_E_valid",   128'(E_valid),   128'(1'b0));
        check("rst_O_valid",   128'(O_valid),   128'(1'b0));
        check("rst_wr_done",   128'(wr_done),   128'(1'b0));
        check("rst_split",     128'(split),     128'(1'b0));
        check("rst_E_mask",    128'(E_mask),    128'(16'h0000));
        rst = 1'b1;
        tick();

        // Aligned, no split: odd bank, 4 bytes at offset 3
        O_ready = 1'b1;
        drive_req(15'h0013, 15'h0000, 2'b10, 64'h00000000AABBCCDD, 32'h0000_1013);
        tick();                          // T0+1
        req_valid = 1'b0;
        check("al_O_valid", 128'(O_valid),    128'(1'b1));
        check("al_E_valid", 128'(E_valid),    128'(1'b0));
        check("al_O_mask",  128'(O_mask),     128'(16'h0078));
        check("al_O_data",  O_data,           128'h000000000000000000AABBCCDD000000);
        check("al_O_paddr", 128'(O_pAddress), 128'(15'h0010));
        check("al_O_vaddr", 128'(O_vAddress), 128'(32'h0000_1013));
        check("al_split",   128'(split),      128'(1'b0));
        check("al_rdy_T1",  128'(req_ready),  128'(1'b0));
        tick();                          // T0+2
        check("al_done_T2", 128'(wr_done),    128'(1'b1));
        check("al_Ov_T2",   128'(O_valid),    128'(1'b0));
        tick();                          // T0+3
        check("al_done_T3", 128'(wr_done),    128'(1'b0));
        check("al_rdy_T3",  128'(req_ready),  128'(1'b1));

        // Split: 8 bytes at offset 14 of an even line
        E_ready = 1'b1; O_ready = 1'b1;
        drive_req(15'h002E, 15'h0030, 2'b11, 64'h8877665544332211, 32'h1234_567E);
        tick();                          // T0+1
        req_valid = 1'b0;
        check("sp_E_valid", 128'(E_valid),    128'(1'b1));
        check("sp_O_valid", 128'(O_valid),    128'(1'b1));
        check("sp_E_mask",  128'(E_mask),     128'(16'hC000));
        check("sp_E_data",  E_data,           128'h22110000000000000000000000000000);
        check("sp_O_mask",  128'(O_mask),     128'(16'h003F));
        check("sp_O_data",  O_data,           128'h00000000000000000000887766554433);
        check("sp_E_paddr", 128'(E_pAddress), 128'(15'h0020));
        check("sp_O_paddr", 128'(O_pAddress), 128'(15'h0030));
        check("sp_E_vaddr", 128'(E_vAddress), 128'(32'h1234_567E));
        check("sp_O_vaddr", 128'(O_vAddress), 128'(32'h1234_5680));
        check("sp_split",   128'(split),      128'(1'b1));
        tick();                          // T0+2
        check("sp_done",    128'(wr_done),    128'(1'b1));
        tick();                          // T0+3

        // Staggered acceptance: even accepts at T0+1, odd held off until T0+4
        E_ready = 1'b1; O_ready = 1'b0;
        drive_req(15'h002E, 15'h0030, 2'b11, 64'h8877665544332211, 32'h1234_567E);
        tick();                          // T0+1
        req_valid = 1'b0;
        check("st_E_valid_T1", 128'(E_valid), 128'(1'b1));
        check("st_O_valid_T1", 128'(O_valid), 128'(1'b1));
        tick();                          // T0+2
        check("st_E_valid_T2", 128'(E_valid), 128'(1'b0));
        check("st_O_valid_T2", 128'(O_valid), 128'(1'b1));
        check("st_done_T2",    128'(wr_done), 128'(1'b0));
        tick();                          // T0+3
        check("st_O_data_T3",  O_data,        128'h00000000000000000000887766554433);
        check("st_done_T3",    128'(wr_done), 128'(1'b0));
        tick();                          // T0+4
        O_ready = 1'b1;
        check("st_O_valid_T4", 128'(O_valid), 128'(1'b1));
        check("st_O_mask_T4",  128'(O_mask),  128'(16'h003F));
        check("st_O_data_T4",  O_data,        128'h00000000000000000000887766554433);
        check("st_done_T4",    128'(wr_done), 128'(1'b0));
        tick();                          // T0+5
        check("st_done_T5",    128'(wr_done), 128'(1'b1));
        tick();

        // Byte store at line end; upper data bytes must be discarded
        E_ready = 1'b1; O_ready = 1'b1;
        drive_req(15'h000F, 15'h0010, 2'b00, 64'hFFFFFFFFFFFFFF5A, 32'h0000_000F);
        tick();
        req_valid = 1'b0;
        check("b15_E_mask",  128'(E_mask),  128'(16'h8000));
        check("b15_E_data",  E_data,        128'h5A000000000000000000000000000000);
        check("b15_O_valid", 128'(O_valid), 128'(1'b0));
        check("b15_split",   128'(split),   128'(1'b0));
        tick(); tick();

        // off + n == 16 exactly: no split
        drive_req(15'h0008, 15'h0010, 2'b11, 64'h0102030405060708, 32'h0000_0008);
        tick();
        req_valid = 1'b0;
        check("edge_E_mask",  128'(E_mask),  128'(16'hFF00));
        check("edge_E_data",  E_data,        128'h01020304050607080000000000000000);
        check("edge_O_valid", 128'(O_valid), 128'(1'b0));
        check("edge_split",   128'(split),   128'(1'b0));
        tick(); tick();

        // Reset while BUSY with odd bank stalled
        O_ready = 1'b0;
        drive_req(15'h0013, 15'h0000, 2'b10, 64'h00000000AABBCCDD, 32'h0000_1013);
        tick();
        req_valid = 1'b0;
        check("mr_O_valid_pre", 128'(O_valid), 128'(1'b1));
        rst = 1'b0;
        #1;
        check("mr_O_valid",   128'(O_valid),   128'(1'b0));
        check("mr_E_valid",   128'(E_valid),   128'(1'b0));
        check("mr_wr_done",   128'(wr_done),   128'(1'b0));
        check("mr_req_ready", 128'(req_ready), 128'(1'b1));
        check("mr_O_mask",    128'(O_mask),    128'(16'h0000));
        tick();
        rst = 1'b1;
        tick();
        O_ready = 1'b1;
        drive_req(15'h0013, 15'h0000, 2'b10, 64'h00000000AABBCCDD, 32'h0000_1013);
        tick();
        req_valid = 1'b0;
        check("mr2_O_valid", 128'(O_valid), 128'(1'b1));
        check("mr2_O_mask",  128'(O_mask),  128'(16'h0078));
        tick();
        check("mr2_done",    128'(wr_done), 128'(1'b1));
        tick();

        // Input backpressure: second request held on req_valid while first is BUSY
        O_ready = 1'b0; E_ready = 1'b1;
        drive_req(15'h0013, 15'h0000, 2'b10, 64'h00000000AABBCCDD, 32'h0000_1013);
        tick();                          // T0+1: A busy
        drive_req(15'h0004, 15'h0010, 2'b01, 64'h000000000000BEEF, 32'h0000_2004);
        check("bp_rdy_T1",    128'(req_ready), 128'(1'b0));
        tick();                          // T0+2
        check("bp_rdy_T2",    128'(req_ready), 128'(1'b0));
        check("bp_A_data",    O_data,          128'h000000000000000000AABBCCDD000000);
        check("bp_A_mask",    128'(O_mask),    128'(16'h0078));
        check("bp_E_valid",   128'(E_valid),   128'(1'b0));
        O_ready = 1'b1;
        tick();                          // T0+3: DONE
        check("bp_done",      128'(wr_done),   128'(1'b1));
        check("bp_rdy_T3",    128'(req_ready), 128'(1'b0));
        tick();                          // T0+4: IDLE, B accepted at the next edge
        check("bp_rdy_T4",    128'(req_ready), 128'(1'b1));
        check("bp_E_valid_T4", 128'(E_valid),  128'(1'b0));
        tick();                          // T0+5: B busy
        req_valid = 1'b0;
        check("bp_B_E_valid", 128'(E_valid),   128'(1'b1));
        check("bp_B_E_mask",  128'(E_mask),    128'(16'h0030));
        check("bp_B_E_data",  E_data,          128'h0000000000000000_0000BEEF00000000);
        check("bp_B_O_valid", 128'(O_valid),   128'(1'b0));
        tick();
        check("bp_B_done",    128'(wr_done),   128'(1'b1));
        tick();
        check("bp_B_rdy",     128'(req_ready), 128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
